// File: rtl/io_bus_responder_pkg.sv
//------------------------------------------------------------------------------
// io_bus_responder_pkg : IO window map shared with the memory/IO router
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package io_bus_responder_pkg;

  localparam int unsigned IO_DW = 24;

  localparam logic [9:0] OFF_LED    = 10'h060;
  localparam logic [9:0] OFF_SW     = 10'h070;
  localparam logic [9:0] OFF_SW_EVT = 10'h074;
  localparam logic [9:0] OFF_TIMER  = 10'h080;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_LED   = 3'd1,
    SEL_SW    = 3'd2,
    SEL_EVT   = 3'd3,
    SEL_TIMER = 3'd4
  } io_sel_e;

  function automatic io_sel_e decode_offset(input logic [9:0] off);
    io_sel_e sel;
    sel = SEL_NONE;
    case (off)
      OFF_LED:    sel = SEL_LED;
      OFF_SW:     sel = SEL_SW;
      OFF_SW_EVT: sel = SEL_EVT;
      OFF_TIMER:  sel = SEL_TIMER;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_bus_responder_switch_debouncer.sv
//------------------------------------------------------------------------------
// io_bus_responder_switch_debouncer : 2-FF synchroniser plus shared stability
// counter; chg_o is a one-cycle mask of bits that changed in stable_o.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_bus_responder_switch_debouncer #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DB_CYC = 230000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] chg_o
);

  localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC - 1);

  logic [WIDTH-1:0] sync1_q, sync_q, cand_q, stable_q, stable_d, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             commit;

  // One counter covers the whole bank: any bit moving restarts the window.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    commit   = 1'b0;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      if (cand_q != stable_q) begin
        stable_d = cand_q;
        commit   = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync_q   <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign chg_o    = commit ? (stable_q ^ cand_q) : '0;

endmodule

`default_nettype wire

// File: rtl/io_bus_responder.sv
//------------------------------------------------------------------------------
// io_bus_responder : LED, debounced switches with change flags and ms timer
// behind the CPU IO window, with a registered 1-cycle read path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 23_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter logic [31:0] IO_BASE     = 32'hFFFFFC00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      wdata,
  input  logic [IO_DW-1:0] switch_in,
  output logic [IO_DW-1:0] io_rdata,
  output logic [IO_DW-1:0] led_out
);

  localparam int unsigned MS_DIV = CLK_HZ / 1000;
  localparam int unsigned DB_CYC = MS_DIV * DEBOUNCE_MS;
  localparam int unsigned PS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(MS_DIV - 1);

  logic             hit;
  io_sel_e          sel;
  logic [IO_DW-1:0] wd;
  logic [IO_DW-1:0] sw_stable, sw_chg;
  logic [IO_DW-1:0] rd_val;

  logic [IO_DW-1:0] led_q, led_d;
  logic [IO_DW-1:0] sw_evt_q, sw_evt_d;
  logic [IO_DW-1:0] io_rdata_q, io_rdata_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [IO_DW-1:0] ms_count_q, ms_count_d;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:IO_DW]};

  assign hit = (addr_in[31:10] == IO_BASE[31:10]);
  assign sel = hit ? decode_offset(addr_in[9:0]) : SEL_NONE;
  assign wd  = wdata[IO_DW-1:0];

  io_bus_responder_switch_debouncer #(
    .WIDTH  (IO_DW),
    .DB_CYC (DB_CYC)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .raw_i    (switch_in),
    .stable_o (sw_stable),
    .chg_o    (sw_chg)
  );

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_LED:   rd_val = led_q;
      SEL_SW:    rd_val = sw_stable;
      SEL_EVT:   rd_val = sw_evt_q;
      SEL_TIMER: rd_val = ms_count_q;
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    led_d      = led_q;
    sw_evt_d   = sw_evt_q;
    ps_d       = ps_q;
    ms_count_d = ms_count_q;
    io_rdata_d = io_read ? rd_val : io_rdata_q;

    if (io_write && sel == SEL_LED) led_d = wd;

    // New change flags are OR-ed in after the clear so a same-edge set wins.
    if (io_write && sel == SEL_EVT) sw_evt_d = sw_evt_q & ~wd;
    sw_evt_d = sw_evt_d | sw_chg;

    if (io_write && sel == SEL_TIMER) begin
      ps_d       = '0;
      ms_count_d = '0;
    end else if (ps_q == PS_MAX) begin
      ps_d       = '0;
      ms_count_d = ms_count_q + 1'b1;
    end else begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q      <= '0;
      sw_evt_q   <= '0;
      io_rdata_q <= '0;
      ps_q       <= '0;
      ms_count_q <= '0;
    end else begin
      led_q      <= led_d;
      sw_evt_q   <= sw_evt_d;
      io_rdata_q <= io_rdata_d;
      ps_q       <= ps_d;
      ms_count_q <= ms_count_d;
    end
  end

  assign io_rdata = io_rdata_q;
  assign led_out  = led_q;

endmodule

`default_nettype wire
